// File: rtl/sram_requester.sv
// sram_requester: turns a valid/ready request stream into rd / we_n strobes for
// the edge-triggered SRAM controller port. Controller-side signals are held for
// the whole access, read data is captured after a fixed latency, and an idle
// gap is inserted so that every access presents a fresh strobe edge.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_RESET  | first cycle after reset release, not yet accepting
// ST_IDLE   | ready for a request, strobes deasserted
// ST_ACTIVE | strobe asserted, counting down the access latency
// ST_GAP    | strobe released, counting down the re-arm gap
module sram_requester #(
    parameter int unsigned BUSY_CYCLES = 6,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [17:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_lb_n,
    input  logic        req_ub_n,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        wr_done,
    output logic        busy,
    output logic        rd,
    output logic        we_n,
    output logic [17:0] iaddr,
    output logic [15:0] dataw,
    output logic        ilb_n,
    output logic        iub_n,
    input  logic [15:0] datar
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam logic [3:0] BUSY_LOAD = 4'(BUSY_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic        we_n_q, we_n_d;
    logic [17:0] iaddr_q, iaddr_d;
    logic [15:0] dataw_q, dataw_d;
    logic        ilb_n_q, ilb_n_d;
    logic        iub_n_q, iub_n_d;
    logic        resp_valid_q, resp_valid_d;
    logic [15:0] resp_rdata_q, resp_rdata_d;
    logic        wr_done_q, wr_done_d;

    // Next-state and next-output decode; pulses default low so they last one cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        we_n_d       = we_n_q;
        iaddr_d      = iaddr_q;
        dataw_d      = dataw_q;
        ilb_n_d      = ilb_n_q;
        iub_n_d      = iub_n_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        wr_done_d    = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid) begin
                    iaddr_d = req_addr;
                    dataw_d = req_wdata;
                    ilb_n_d = req_lb_n;
                    iub_n_d = req_ub_n;
                    if (req_we) begin
                        we_n_d = 1'b0;
                    end else begin
                        rd_d = 1'b1;
                    end
                    cnt_d   = BUSY_LOAD;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == 4'd0) begin
                    rd_d   = 1'b0;
                    we_n_d = 1'b1;
                    // rd_q still tells us which kind of access is finishing
                    if (rd_q) begin
                        resp_rdata_d[7:0]  = ilb_n_q ? 8'h00 : datar[7:0];
                        resp_rdata_d[15:8] = iub_n_q ? 8'h00 : datar[15:8];
                        resp_valid_d       = 1'b1;
                    end else begin
                        wr_done_d = 1'b1;
                    end
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RESET;
            cnt_q        <= 4'd0;
            rd_q         <= 1'b0;
            we_n_q       <= 1'b1;
            iaddr_q      <= 18'd0;
            dataw_q      <= 16'd0;
            ilb_n_q      <= 1'b1;
            iub_n_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 16'd0;
            wr_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            we_n_q       <= we_n_d;
            iaddr_q      <= iaddr_d;
            dataw_q      <= dataw_d;
            ilb_n_q      <= ilb_n_d;
            iub_n_q      <= iub_n_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            wr_done_q    <= wr_done_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rd         = rd_q;
    assign we_n       = we_n_q;
    assign iaddr      = iaddr_q;
    assign dataw      = dataw_q;
    assign ilb_n      = ilb_n_q;
    assign iub_n      = iub_n_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign wr_done    = wr_done_q;

endmodule

// File: tb/tb_sram_requester.sv
// Testbench for sram_requester: behavioural SRAM device behind the controller
// port, a reference memory updated per request, and a scoreboard that a
// monitor drains whenever the block emits resp_valid or wr_done.
module tb_sram_requester;

    localparam int BUSY = 6;
    localparam int GAP  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [17:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_lb_n;
    logic        req_ub_n;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        wr_done;
    logic        busy;
    logic        rd;
    logic        we_n;
    logic [17:0] iaddr;
    logic [15:0] dataw;
    logic        ilb_n;
    logic        iub_n;
    logic [15:0] datar;

    sram_requester #(.BUSY_CYCLES(BUSY), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_lb_n(req_lb_n), .req_ub_n(req_ub_n),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .wr_done(wr_done),
        .busy(busy), .rd(rd), .we_n(we_n), .iaddr(iaddr), .dataw(dataw),
        .ilb_n(ilb_n), .iub_n(iub_n), .datar(datar)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem_dev [bit [17:0]];
    logic [15:0] mem_ref [bit [17:0]];

    int vectors     = 0;
    int miscompares = 0;

    // expected controller-side contents of the access in flight
    logic [17:0] exp_addr;
    logic [15:0] exp_wd;
    logic        exp_lb, exp_ub, exp_we;
    int          gap_last = 0;

    function automatic logic [15:0] dflt(input logic [17:0] a);
        return a[15:0] ^ 16'hC3A5 ^ {14'b0, a[17:16]};
    endfunction

    function automatic logic [15:0] dev_peek(input logic [17:0] a);
        return mem_dev.exists(a) ? mem_dev[a] : dflt(a);
    endfunction

    function automatic logic [15:0] ref_peek(input logic [17:0] a);
        return mem_ref.exists(a) ? mem_ref[a] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Issue one request: garbage is presented while the block is not ready,
    // the real request once it is; expected response is queued at the accept edge.
    task automatic issue(input bit we, input logic [17:0] a, input logic [15:0] wd,
                         input bit lb, input bit ub, output time t_acc);
        int          n;
        exp_t        e;
        logic [15:0] m;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            req_valid = 1'b1;
            req_we    = 1'($urandom);
            req_addr  = 18'($urandom);
            req_wdata = 16'($urandom);
            req_lb_n  = 1'($urandom);
            req_ub_n  = 1'($urandom);
            n++;
            @(negedge clk);
        end
        chk("accept_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_lb_n  = lb;
        req_ub_n  = ub;
        @(posedge clk);
        t_acc    = $time;
        exp_addr = a;
        exp_wd   = wd;
        exp_lb   = lb;
        exp_ub   = ub;
        exp_we   = we;
        m = ref_peek(a);
        if (we) begin
            if (!lb) m[7:0] = wd[7:0];
            if (!ub) m[15:8] = wd[15:8];
            mem_ref[a] = m;
            e.is_wr = 1'b1;
            e.data  = 16'h0;
        end else begin
            e.is_wr = 1'b0;
            e.data  = {ub ? 8'h00 : m[15:8], lb ? 8'h00 : m[7:0]};
        end
        exp_q.push_back(e);
    endtask

    // SRAM device model: writes on the falling we_n edge, read data follows iaddr
    initial begin
        logic        prev_we_n;
        logic [15:0] m;
        prev_we_n = 1'b1;
        datar     = 16'h0;
        forever begin
            @(negedge clk);
            if (reset_n && !we_n && prev_we_n) begin
                m = dev_peek(iaddr);
                if (!ilb_n) m[7:0] = dataw[7:0];
                if (!iub_n) m[15:8] = dataw[15:8];
                mem_dev[iaddr] = m;
            end
            prev_we_n = we_n;
            datar     = dev_peek(iaddr);
        end
    end

    // Monitor: scoreboard pops, strobe width/gap/exclusivity and hold checks
    initial begin
        int   rd_run, we_run, idle_run;
        bit   strobe, strobe_prev, seen;
        exp_t e;
        rd_run = 0; we_run = 0; idle_run = 0; strobe_prev = 0; seen = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rd_run = 0; we_run = 0; idle_run = 0; strobe_prev = 0; seen = 0;
                continue;
            end
            if (resp_valid || wr_done) begin
                if (resp_valid && wr_done) begin
                    chk("pulse_overlap", 32'({resp_valid, wr_done}), 32'd1);
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'({resp_valid, wr_done}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_kind", 32'(wr_done), 32'(e.is_wr));
                    if (!e.is_wr) chk("rdata", 32'(resp_rdata), 32'(e.data));
                end
            end
            strobe = rd || !we_n;
            if (strobe) begin
                chk("strobe_excl", 32'(rd && !we_n), 32'd0);
                chk("strobe_kind", 32'(!we_n), 32'(exp_we));
                chk("hold_addr", 32'(iaddr), 32'(exp_addr));
                chk("hold_lanes", 32'({ilb_n, iub_n}), 32'({exp_lb, exp_ub}));
                if (!we_n) chk("hold_wdata", 32'(dataw), 32'(exp_wd));
            end else if (seen) begin
                chk("idle_hold_addr", 32'(iaddr), 32'(exp_addr));
            end
            if (rd) rd_run++;
            else if (rd_run > 0) begin
                chk("rd_width", 32'(rd_run), 32'(BUSY));
                rd_run = 0;
            end
            if (!we_n) we_run++;
            else if (we_run > 0) begin
                chk("we_width", 32'(we_run), 32'(BUSY));
                we_run = 0;
            end
            if (strobe && !strobe_prev) begin
                gap_last = idle_run;
                if (seen) chk("gap_min", 32'(idle_run >= GAP + 1), 32'd1);
                seen     = 1;
                idle_run = 0;
            end else if (!strobe) begin
                idle_run++;
            end
            strobe_prev = strobe;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        time         t1, t2;
        int          n;
        logic [17:0] pool [8];
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 18'h0;
        req_wdata = 16'h0;
        req_lb_n  = 1'b1;
        req_ub_n  = 1'b1;

        // reset values and release sequence
        repeat (3) @(negedge clk);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_we_n", 32'(we_n), 32'd1);
        chk("rst_iaddr", 32'(iaddr), 32'd0);
        chk("rst_dataw", 32'(dataw), 32'd0);
        chk("rst_lanes", 32'({ilb_n, iub_n}), 32'd3);
        chk("rst_pulses", 32'({resp_valid, wr_done}), 32'd0);
        chk("rst_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b1;
        chk("rel_ready0", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_ready1", 32'(req_ready), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);

        // word read with exact latency
        mem_dev[18'h12345] = 16'hBEEF;
        mem_ref[18'h12345] = 16'hBEEF;
        issue(1'b0, 18'h12345, 16'h0, 1'b0, 1'b0, t1);
        #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("read_pre_rd", 32'(rd), 32'd1);
        chk("read_pre_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("read_rd_off", 32'(rd), 32'd0);
        chk("read_valid", 32'(resp_valid), 32'd1);
        chk("read_data", 32'(resp_rdata), 32'h0000BEEF);

        // byte reads
        issue(1'b0, 18'h12345, 16'h0, 1'b0, 1'b1, t1);
        #1 req_valid = 1'b0;
        issue(1'b0, 18'h12345, 16'h0, 1'b1, 1'b0, t1);
        #1 req_valid = 1'b0;
        issue(1'b0, 18'h12345, 16'h0, 1'b1, 1'b1, t1);
        #1 req_valid = 1'b0;

        // write to the top address, then back-to-back write + read
        issue(1'b1, 18'h3FFFF, 16'hA55A, 1'b0, 1'b0, t1);
        #1 req_valid = 1'b0;
        issue(1'b1, 18'h00777, 16'h1234, 1'b0, 1'b0, t1);
        issue(1'b0, 18'h00777, 16'h0, 1'b0, 1'b0, t2);
        #1 req_valid = 1'b0;
        chk("b2b_spacing", 32'(t2 - t1), 32'(10 * (BUSY + GAP + 1)));
        @(negedge clk); #1;
        chk("b2b_gap", 32'(gap_last), 32'(GAP + 1));

        // reset three cycles into a read
        issue(1'b0, 18'h3FFFF, 16'h0, 1'b0, 1'b0, t1);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_rd", 32'(rd), 32'd0);
        chk("midrst_pulse", 32'({resp_valid, wr_done}), 32'd0);
        chk("midrst_pending", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_ready0", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("midrst_ready1", 32'(req_ready), 32'd1);
        issue(1'b0, 18'h3FFFF, 16'h0, 1'b0, 1'b0, t1);
        #1 req_valid = 1'b0;

        // randomized traffic over a small address pool
        pool = '{18'h00000, 18'h3FFFF, 18'h12345, 18'h00777,
                 18'h20001, 18'h1FFFE, 18'h00010, 18'h2AAAA};
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 3);
            if (n > 0) begin
                @(negedge clk);
                req_valid = 1'b0;
                repeat (n - 1) @(negedge clk);
            end
            issue(1'($urandom), pool[$urandom_range(0, 7)], 16'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), t1);
        end
        #1 req_valid = 1'b0;

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
